// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: D = A - B - bin, one bit per clock, LSB first.
// A full-subtractor cell with a registered borrow is stepped WIDTH times per
// operation. A start/busy/done handshake sequences operations. Results (D,
// borrow, ovf) update only on the final edge and are held until the next one.
module serial_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             borrow,
  output logic             ovf
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic             br_q;
  logic [WIDTH-1:0] res_q;
  logic             a_msb_q;
  logic             b_msb_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] d_q;
  logic             borrow_q;
  logic             ovf_q;

  logic             d_bit_c;
  logic             br_d;
  logic [WIDTH-1:0] res_d;
  logic             last_c;

  // Full-subtractor cell on the current LSBs plus the next result word.
  always_comb begin
    d_bit_c = a_sh_q[0] ^ b_sh_q[0] ^ br_q;
    br_d    = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & br_q);
    res_d   = {d_bit_c, res_q[WIDTH-1:1]};
    last_c  = (cnt_q == CW'(WIDTH - 1));
  end

  // Control FSM and datapath: capture on accepted start, one bit per RUN edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      br_q     <= 1'b0;
      res_q    <= '0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      d_q      <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            a_sh_q  <= A;
            b_sh_q  <= B;
            br_q    <= bin;
            cnt_q   <= '0;
            res_q   <= '0;
            a_msb_q <= A[WIDTH-1];
            b_msb_q <= B[WIDTH-1];
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          a_sh_q <= a_sh_q >> 1;
          b_sh_q <= b_sh_q >> 1;
          br_q   <= br_d;
          res_q  <= res_d;
          cnt_q  <= cnt_q + CW'(1);
          if (last_c) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            d_q      <= res_d;
            borrow_q <= br_d;
            // Overflow only possible when operand signs differ.
            ovf_q    <= (a_msb_q != b_msb_q) & (res_d[WIDTH-1] != a_msb_q);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign D      = d_q;
  assign borrow = borrow_q;
  assign ovf    = ovf_q;

endmodule
